// File: rtl/register_file.sv
// Architectural register file with rename tags: 32 entries of {value, busy, tag}.
// Reads are combinational and forward a same-cycle matching commit or a ready ROB lookup.
module register_file #(
    parameter int ROB_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                clear,
    input  logic                commit_en,
    input  logic [4:0]          commit_rd,
    input  logic [31:0]         commit_val,
    input  logic [ROB_BITS-1:0] commit_rob_id,
    input  logic                dep_en,
    input  logic [4:0]          dep_rd,
    input  logic [ROB_BITS-1:0] dep_rob_id,
    input  logic [4:0]          rs1,
    input  logic [4:0]          rs2,
    output logic [ROB_BITS-1:0] q1_rob_id,
    output logic [ROB_BITS-1:0] q2_rob_id,
    input  logic                q1_ready,
    input  logic [31:0]         q1_val,
    input  logic                q2_ready,
    input  logic [31:0]         q2_val,
    output logic                rs1_busy,
    output logic                rs2_busy,
    output logic [31:0]         rs1_val,
    output logic [31:0]         rs2_val,
    output logic [ROB_BITS-1:0] rs1_tag,
    output logic [ROB_BITS-1:0] rs2_tag
);

    logic [31:0][31:0]         r_value;
    logic [31:0]               r_busy;
    logic [31:0][ROB_BITS-1:0] r_tag;

    logic w_commit_ok;
    logic w_dep_ok;

    assign w_commit_ok = commit_en && (commit_rd != 5'd0);
    assign w_dep_ok    = dep_en && (dep_rd != 5'd0);

    // x0 is never written, so its entry stays at the reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
            r_busy  <= '0;
            r_tag   <= '0;
        end else if (rdy) begin
            if (clear) begin
                r_busy <= '0;
                r_tag  <= '0;
            end else begin
                if (w_commit_ok) begin
                    r_value[commit_rd] <= commit_val;
                    if (r_tag[commit_rd] == commit_rob_id)
                        r_busy[commit_rd] <= 1'b0;
                end
                // Issued after the commit so a same-register rename takes precedence.
                if (w_dep_ok) begin
                    r_busy[dep_rd] <= 1'b1;
                    r_tag[dep_rd]  <= dep_rob_id;
                end
            end
        end
    end

    always_comb begin
        q1_rob_id = r_tag[rs1];
        rs1_tag   = r_tag[rs1];
        rs1_busy  = 1'b0;
        rs1_val   = 32'd0;
        if (!r_busy[rs1]) begin
            rs1_val = r_value[rs1];
        end else if (commit_en && (commit_rd == rs1) && (commit_rob_id == r_tag[rs1])) begin
            rs1_val = commit_val;
        end else if (q1_ready) begin
            rs1_val = q1_val;
        end else begin
            rs1_busy = 1'b1;
        end
    end

    always_comb begin
        q2_rob_id = r_tag[rs2];
        rs2_tag   = r_tag[rs2];
        rs2_busy  = 1'b0;
        rs2_val   = 32'd0;
        if (!r_busy[rs2]) begin
            rs2_val = r_value[rs2];
        end else if (commit_en && (commit_rd == rs2) && (commit_rob_id == r_tag[rs2])) begin
            rs2_val = commit_val;
        end else if (q2_ready) begin
            rs2_val = q2_val;
        end else begin
            rs2_busy = 1'b1;
        end
    end

endmodule
